// File: rtl/if_stage_fetch.sv
// if_stage_fetch: instruction-fetch stage plus IF/ID pipeline register.
// Keeps the PC and issues at most one word fetch at a time to instruction
// memory. Fetched instructions go to decode through the IF/ID register.
// Redirects from EX and stalls from the hazard unit act on both the fetch
// FSM and IF/ID. Redirect always takes priority over stall.
// Optional build macro FETCH_PERF_EN adds free-running performance counters.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_redirect_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    // REQ: request on the bus; WAIT: awaiting the response;
    // HOLD: response parked while decode is stalled; DROP: awaiting a stale response
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_instr_q;
    logic        if_id_valid_q;
    logic [31:0] if_id_pc_q;
    logic [31:0] if_id_pc_plus4_q;
    logic [31:0] if_id_instr_q;

    logic        handshake;
    logic        deliver;
    logic        capture;
    logic [31:0] deliver_instr;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

    // The low two bits of the target are meaningless for word fetches
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4        = pc_q + 32'd4;

    // State register for the fetch FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-PC selection; redirect overrides everything else
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_REQ: begin
                if (handshake) begin
                    state_d = redirect ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (imem_rsp_valid) begin
                    state_d = stall ? ST_HOLD : ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect || !stall) begin
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
        if (redirect) begin
            pc_d = redirect_target;
        end else if (deliver) begin
            pc_d = pc_plus4;
        end
    end

    // FSM outputs: bus request plus the IF/ID load and buffer capture strobes
    always_comb begin
        imem_req_valid = rst_n && (state_q == ST_REQ);
        imem_req_addr  = pc_q & 32'hFFFF_FFFC;
        handshake      = imem_req_valid && imem_req_ready;
        deliver        = 1'b0;
        capture        = 1'b0;
        deliver_instr  = imem_rsp_data;
        if (state_q == ST_HOLD) begin
            deliver_instr = hold_instr_q;
            deliver       = !redirect && !stall;
        end else if (state_q == ST_WAIT && imem_rsp_valid && !redirect) begin
            deliver = !stall;
            capture = stall;
        end
    end

    // Program counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Holding buffer for a response that arrived while decode was stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_instr_q <= NOP_INSTR;
        end else if (capture) begin
            hold_instr_q <= imem_rsp_data;
        end
    end

    // IF/ID register: flush on redirect, hold on stall, else load or bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid_q    <= 1'b0;
            if_id_pc_q       <= 32'h0000_0000;
            if_id_pc_plus4_q <= 32'h0000_0004;
            if_id_instr_q    <= NOP_INSTR;
        end else if (redirect) begin
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
        end else if (!stall) begin
            if (deliver) begin
                if_id_valid_q    <= 1'b1;
                if_id_pc_q       <= pc_q;
                if_id_pc_plus4_q <= pc_plus4;
                if_id_instr_q    <= deliver_instr;
            end else begin
                if_id_valid_q <= 1'b0;
                if_id_instr_q <= NOP_INSTR;
            end
        end
    end

    assign if_id_valid    = if_id_valid_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_instr    = if_id_instr_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_redirect_q;
    logic [31:0] perf_bubble_q;

    // Performance counters: valid loads, redirect cycles, unstalled bubble cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q    <= 32'd0;
            perf_redirect_q <= 32'd0;
            perf_bubble_q   <= 32'd0;
        end else begin
            if (deliver) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (redirect) begin
                perf_redirect_q <= perf_redirect_q + 32'd1;
            end
            if (!if_id_valid_q && !stall) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt    = perf_fetch_q;
    assign perf_redirect_cnt = perf_redirect_q;
    assign perf_bubble_cnt   = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// tb_if_stage_fetch: directed vector table, hand-written corner sequences and
// a randomized run against a transaction-level fetch model with a memory model.
module tb_if_stage_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    if_stage_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_instr   (if_id_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_redirect_cnt(perf_redirect_cnt),
        .perf_bubble_cnt  (perf_bubble_cnt)
`endif
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
        logic [31:0] eInstr;
    } vec_t;

    vec_t vecQ[$];

    task automatic addVec(input logic st, input logic rd, input logic [31:0] rpc,
                          input logic rdy, input logic rv, input logic [31:0] rdata,
                          input logic eReq, input logic [31:0] eAddr,
                          input logic eValid, input logic [31:0] ePc, input logic [31:0] eInstr);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.ePc = ePc; v.eInstr = eInstr;
        vecQ.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs; caller is positioned just after a negedge
    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                                 input logic rdy, input logic rv, input logic [31:0] rdata);
        stall          = st;
        redirect       = rd;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rdata;
        #1;
    endtask

    task automatic checkIfId(input string tag, input logic v, input logic [31:0] p, input logic [31:0] ins);
        checkOutput({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, v});
        checkOutput({tag, ".if_id_pc"}, if_id_pc, p);
        checkOutput({tag, ".if_id_pc_plus4"}, if_id_pc_plus4, p + 32'd4);
        checkOutput({tag, ".if_id_instr"}, if_id_instr, ins);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("reset.req_valid", {31'd0, imem_req_valid}, 32'd0);
        checkIfId("reset", 1'b0, 32'd0, NOP);
`ifdef FETCH_PERF_EN
        checkOutput("reset.perf_fetch", perf_fetch_cnt, 32'd0);
`endif
        rst_n = 1'b1;
    endtask

    // Stimulus-side memory: word contents derived from the address
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Transaction-level reference model state
    logic [31:0] mPc;
    bit          mOut;
    bit          mStale;
    logic [31:0] mBuf[$];
    bit          mIfValid;
    logic [31:0] mIfPc;
    logic [31:0] mIfInstr;
    int unsigned mFetch, mRedir, mBubble;

    bit          memPending;
    int          memDue;
    logic [31:0] memData;

    task automatic modelReset();
        mPc = 32'd0; mOut = 0; mStale = 0; mBuf.delete();
        mIfValid = 0; mIfPc = 32'd0; mIfInstr = NOP;
        mFetch = 0; mRedir = 0; mBubble = 0;
        memPending = 0; memDue = 0; memData = 32'd0;
    endtask

    // Advances the model by one clock edge using the inputs driven this cycle
    task automatic modelStep(input logic st, input logic rd, input logic [31:0] rpc,
                             input logic rdy, input logic rv, input logic [31:0] rdata, input int cyc);
        bit          reqV;
        bit          accept;
        bit          deliver;
        logic [31:0] dInstr;
        logic [31:0] acceptAddr;
        reqV       = !mOut && (mBuf.size() == 0);
        accept     = reqV && rdy;
        acceptAddr = mPc;
        deliver    = 0;
        dInstr     = NOP;
        if (!rd && !st) begin
            if (mBuf.size() != 0) begin
                deliver = 1; dInstr = mBuf[0];
            end else if (rv && !mStale) begin
                deliver = 1; dInstr = rdata;
            end
        end
        if (!mIfValid && !st) mBubble++;
        if (rd) mRedir++;
        if (deliver) mFetch++;
        if (rd) begin
            mIfValid = 0; mIfInstr = NOP;
        end else if (!st) begin
            if (deliver) begin
                mIfValid = 1; mIfPc = mPc; mIfInstr = dInstr;
            end else begin
                mIfValid = 0; mIfInstr = NOP;
            end
        end
        if (rd || deliver) mBuf.delete();
        else if (rv && !mStale && st) mBuf.push_back(rdata);
        if (rv) begin
            mOut = 0; mStale = 0; memPending = 0;
        end
        if (accept) begin
            mOut = 1; mStale = rd;
            memPending = 1;
            memDue = cyc + 1 + int'($urandom_range(0, 2));
            memData = memWord(acceptAddr);
        end else if (rd && mOut) begin
            mStale = 1;
        end
        if (rd) mPc = rpc & 32'hFFFF_FFFC;
        else if (deliver) mPc = mPc + 32'd4;
    endtask

    initial begin
        rst_n = 1'b0;
        // Directed table: inputs for one cycle | pre-edge request | post-edge IF/ID
        addVec(0,0,32'h0,       1,0,32'h0,         1,32'h0,        0,32'h0,        NOP);
        addVec(0,0,32'h0,       0,1,32'h0010_0093, 0,32'h0,        1,32'h0,        32'h0010_0093);
        addVec(0,0,32'h0,       1,0,32'h0,         1,32'h4,        0,32'h0,        NOP);
        addVec(1,0,32'h0,       0,1,32'h0020_0113, 0,32'h4,        0,32'h0,        NOP);
        addVec(1,0,32'h0,       0,0,32'h0,         0,32'h4,        0,32'h0,        NOP);
        addVec(0,0,32'h0,       0,0,32'h0,         0,32'h4,        1,32'h4,        32'h0020_0113);
        addVec(0,0,32'h0,       0,0,32'h0,         1,32'h8,        0,32'h4,        NOP);
        addVec(0,1,32'h200,     0,0,32'h0,         1,32'h8,        0,32'h4,        NOP);
        addVec(0,0,32'h0,       0,0,32'h0,         1,32'h200,      0,32'h4,        NOP);
        addVec(0,0,32'h0,       1,0,32'h0,         1,32'h200,      0,32'h4,        NOP);
        addVec(0,0,32'h0,       0,1,32'h0030_0193, 0,32'h200,      1,32'h200,      32'h0030_0193);
        addVec(1,1,32'h302,     1,0,32'h0,         1,32'h204,      0,32'h200,      NOP);
        addVec(0,0,32'h0,       0,0,32'h0,         0,32'h300,      0,32'h200,      NOP);
        addVec(0,0,32'h0,       0,1,32'hDEAD_BEEF, 0,32'h300,      0,32'h200,      NOP);
        addVec(0,0,32'h0,       1,0,32'h0,         1,32'h300,      0,32'h200,      NOP);
        addVec(0,1,32'h103,     0,0,32'h0,         0,32'h300,      0,32'h200,      NOP);
        addVec(0,0,32'h0,       0,1,32'hBAD0_BAD0, 0,32'h100,      0,32'h200,      NOP);
        addVec(0,0,32'h0,       1,0,32'h0,         1,32'h100,      0,32'h200,      NOP);
        addVec(0,0,32'h0,       0,1,32'h0040_0213, 0,32'h100,      1,32'h100,      32'h0040_0213);
        addVec(0,1,32'hFFFF_FFFC,0,0,32'h0,        1,32'h104,      0,32'h100,      NOP);
        addVec(0,0,32'h0,       1,0,32'h0,         1,32'hFFFF_FFFC,0,32'h100,      NOP);
        addVec(0,0,32'h0,       0,1,32'h0050_0293, 0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,32'h0050_0293);
        addVec(1,0,32'h0,       0,0,32'h0,         1,32'h0,        1,32'hFFFF_FFFC,32'h0050_0293);
        addVec(0,0,32'h0,       0,0,32'h0,         1,32'h0,        0,32'hFFFF_FFFC,NOP);

        doReset();
        foreach (vecQ[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecQ[i].st, vecQ[i].rd, vecQ[i].rpc, vecQ[i].rdy, vecQ[i].rv, vecQ[i].rdata);
            checkOutput({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, vecQ[i].eReq});
            checkOutput({tag, ".req_addr"}, imem_req_addr, vecQ[i].eAddr);
            @(posedge clk); #1;
            checkIfId(tag, vecQ[i].eValid, vecQ[i].ePc, vecQ[i].eInstr);
            @(negedge clk);
        end

        // HOLD interrupted by redirect: the parked instruction must never reach decode
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
        checkOutput("hold.req_valid", {31'd0, imem_req_valid}, 32'd1);
        @(posedge clk); @(negedge clk);
        applyStimulus(1, 0, 32'h0, 0, 1, 32'h1111_1111);
        @(posedge clk); #1;
        checkIfId("hold.park", 1'b0, 32'hFFFF_FFFC, NOP);
        @(negedge clk);
        applyStimulus(1, 1, 32'h41, 0, 0, 32'h0);
        checkOutput("hold.req_idle", {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h0);
        checkOutput("hold.redir_addr", imem_req_addr, 32'h40);
        checkOutput("hold.redir_req", {31'd0, imem_req_valid}, 32'd1);
        @(posedge clk); @(negedge clk);
        applyStimulus(0, 0, 32'h0, 0, 1, 32'h2222_2222);
        @(posedge clk); #1;
        checkIfId("hold.after", 1'b1, 32'h40, 32'h2222_2222);
        @(negedge clk);

        // Randomized run against the reference model
        doReset();
        modelReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        st, rd, rdy, rv;
            logic [31:0] rpc, rdata;
            st    = ($urandom_range(0, 3) == 0);
            rd    = ($urandom_range(0, 9) == 0);
            rpc   = $urandom;
            rdy   = ($urandom_range(0, 2) != 0);
            rv    = memPending && (memDue == cyc);
            rdata = rv ? memData : $urandom;
            applyStimulus(st, rd, rpc, rdy, rv, rdata);
            checkOutput("rand.req_valid", {31'd0, imem_req_valid},
                        {31'd0, (!mOut && mBuf.size() == 0)});
            checkOutput("rand.req_addr", imem_req_addr, mPc);
            checkIfId("rand", mIfValid, mIfPc, mIfInstr);
            @(posedge clk);
            modelStep(st, rd, rpc, rdy, rv, rdata, cyc);
            @(negedge clk);
        end
`ifdef FETCH_PERF_EN
        checkOutput("perf.fetch", perf_fetch_cnt, mFetch);
        checkOutput("perf.redirect", perf_redirect_cnt, mRedir);
        checkOutput("perf.bubble", perf_bubble_cnt, mBubble);
`endif
        checkOutput("rand.some_fetches", {31'd0, (mFetch > 100)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
